// File: rtl/seg7_scan_sequencer.sv
// Four-digit BCD scan sequencer on the 8-in/8-out pin bank: nibbles are
// double-buffered and committed at a frame boundary, then multiplexed onto one
// 7-segment group with a frame-sync bit on io_out[7].
module seg7_scan_sequencer #(
  parameter int unsigned PRESCALE = 256
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  localparam int unsigned CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] PS_LAST = CW'(PRESCALE - 1);

  logic       clk;
  logic       rst;
  logic [3:0] nib_i;
  logic       wr_i;
  logic       run_i;

  assign clk   = io_in[0];
  assign rst   = io_in[1];
  assign nib_i = io_in[5:2];
  assign wr_i  = io_in[6];
  assign run_i = io_in[7];

  logic          wr_q,      wr_d;
  logic [1:0]    wptr_q,    wptr_d;
  logic          pending_q, pending_d;
  logic [1:0]    idx_q,     idx_d;
  logic [CW-1:0] presc_q,   presc_d;
  logic [3:0]    wbuf_q [4];
  logic [3:0]    wbuf_d [4];
  logic [3:0]    dbuf_q [4];
  logic [3:0]    dbuf_d [4];
  logic [7:0]    out_q,     out_d;

  logic wr_edge;
  logic advance;
  logic commit;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  always_comb begin
    wr_edge   = wr_i & ~wr_q;
    advance   = run_i && (presc_q == PS_LAST);
    // A frozen display has no frame boundary to wait for, so commit at once.
    commit    = pending_q && (!run_i || (advance && (idx_q == 2'd3)));

    wr_d      = wr_i;
    wptr_d    = wptr_q;
    pending_d = pending_q;
    idx_d     = idx_q;
    presc_d   = presc_q;
    wbuf_d    = wbuf_q;
    dbuf_d    = dbuf_q;

    if (wr_edge && !pending_q) begin
      wbuf_d[wptr_q] = nib_i;
      wptr_d         = wptr_q + 2'd1;
      if (wptr_q == 2'd3) pending_d = 1'b1;
    end

    if (commit) begin
      dbuf_d    = wbuf_q;
      pending_d = 1'b0;
    end

    if (run_i) begin
      if (advance) begin
        presc_d = '0;
        idx_d   = idx_q + 2'd1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end

    out_d = {(idx_q == 2'd0), seg_decode(dbuf_q[idx_q])};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q      <= 1'b0;
      wptr_q    <= '0;
      pending_q <= 1'b0;
      idx_q     <= '0;
      presc_q   <= '0;
      out_q     <= '0;
      for (int i = 0; i < 4; i++) begin
        wbuf_q[i] <= '0;
        dbuf_q[i] <= '0;
      end
    end else begin
      wr_q      <= wr_d;
      wptr_q    <= wptr_d;
      pending_q <= pending_d;
      idx_q     <= idx_d;
      presc_q   <= presc_d;
      out_q     <= out_d;
      for (int i = 0; i < 4; i++) begin
        wbuf_q[i] <= wbuf_d[i];
        dbuf_q[i] <= dbuf_d[i];
      end
    end
  end

  assign io_out = out_q;

endmodule

// File: tb/tb_seg7_scan_sequencer.sv
// Directed bench for seg7_scan_sequencer at PRESCALE=4: the driver schedules
// hand-computed pin values per clock edge, a monitor compares them on negedge.
module tb_seg7_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr;
  logic       run;
  logic [3:0] nib;
  logic [7:0] io_in;
  logic [7:0] io_out;

  assign io_in = {run, wr, nib, rst, clk};

  seg7_scan_sequencer #(.PRESCALE(4)) dut (
    .io_in  (io_in),
    .io_out (io_out)
  );

  // ---------------- clock / cycle counter ----------------
  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int         exp_cyc_q[$];
  string      tag_q[$];
  int         checks = 0;
  int         errors = 0;

  task automatic expect_at(input int off, input logic [7:0] v, input string tag);
    exp_q.push_back(v);
    exp_cyc_q.push_back(cyc + off);
    tag_q.push_back(tag);
  endtask

  task automatic monitor_loop();
    logic [7:0] ev;
    int         ec;
    string      tg;
    forever begin
      @(negedge clk);
      while (exp_cyc_q.size() != 0 && exp_cyc_q[0] <= cyc) begin
        ev = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        tg = tag_q.pop_front();
        checks++;
        if (ec != cyc) begin
          errors++;
          $display("FAIL %s: check scheduled for cycle %0d seen at cycle %0d", tg, ec, cyc);
        end else if (io_out !== ev) begin
          errors++;
          $display("FAIL %s: cycle %0d io_out=%02h expected %02h", tg, cyc, io_out, ev);
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_pulse(input logic [3:0] v);
    nib = v;
    wr  = 1'b1;
    tick();
    wr  = 1'b0;
    tick();
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    tick();
    expect_at(0, 8'h00, tag);
    rst = 1'b0;
  endtask

  // Digit pins per idx slot for the scan test: old set, 5678 set, 9/0/10/15 set.
  logic [7:0] t34 [12] = '{8'h86, 8'h5B, 8'h4F, 8'h66,
                           8'hED, 8'h7D, 8'h07, 8'h7F,
                           8'hEF, 8'h3F, 8'h00, 8'h00};

  int base;

  initial begin
    rst = 1'b1;
    wr  = 1'b0;
    run = 1'b0;
    nib = 4'd0;
    fork
      monitor_loop();
    join_none
    tick();

    // 1: scanning zeros -> sync high 4 cycles, low 12
    run = 1'b1;
    do_reset("t1_reset");
    for (int k = 1; k <= 20; k++)
      expect_at(k, (k <= 4 || k >= 17) ? 8'hBF : 8'h3F, "t1_scan_zero");
    repeat (20) tick();

    // 2: load 1,2,3,4 frozen -> immediate commit
    run = 1'b0;
    do_reset("t2_reset");
    expect_at(1, 8'hBF, "t2_after_reset");
    wr_pulse(4'd1);
    wr_pulse(4'd2);
    wr_pulse(4'd3);
    wr_pulse(4'd4);
    expect_at(0, 8'hBF, "t2_before_commit");
    expect_at(1, 8'h86, "t2_after_commit");
    tick();

    // 3+4: scan, reload mid-frame, dropped extra writes, second reload
    run  = 1'b1;
    base = cyc;
    for (int k = 1; k <= 48; k++)
      expect_at(k, t34[(k-1)/4], "t34_scan");
    expect_at(49, 8'hEF, "t34_wrap");
    wr_pulse(4'd5);
    wr_pulse(4'd6);
    wr_pulse(4'd7);
    wr_pulse(4'd8);
    wr_pulse(4'd1);
    wr_pulse(4'd1);
    while (cyc < base + 16) tick();
    wr_pulse(4'd9);
    wr_pulse(4'd0);
    wr_pulse(4'd10);
    wr_pulse(4'd15);
    while (cyc < base + 49) tick();

    // 5: held wr writes once; run 1->0 freezes the scan
    run = 1'b0;
    do_reset("t5_reset");
    nib = 4'd3;
    wr  = 1'b1;
    repeat (10) tick();
    wr  = 1'b0;
    tick();
    wr_pulse(4'd4);
    wr_pulse(4'd5);
    wr_pulse(4'd6);
    expect_at(0, 8'hBF, "t5_before_commit");
    expect_at(1, 8'hCF, "t5_after_commit");
    tick();
    run = 1'b1;
    for (int k = 1; k <= 6; k++)
      expect_at(k, (k <= 4) ? 8'hCF : 8'h66, "t5_scan");
    repeat (6) tick();
    run = 1'b0;
    for (int k = 1; k <= 10; k++)
      expect_at(k, 8'h66, "t5_frozen");
    repeat (10) tick();

    // 6: reset after a partial load discards it
    wr_pulse(4'd7);
    wr_pulse(4'd8);
    run = 1'b1;
    repeat (3) tick();
    do_reset("t6_reset");
    run = 1'b0;
    expect_at(1, 8'hBF, "t6_after_reset");
    wr_pulse(4'd9);
    wr_pulse(4'd1);
    wr_pulse(4'd1);
    wr_pulse(4'd1);
    expect_at(0, 8'hBF, "t6_before_commit");
    expect_at(1, 8'hEF, "t6_after_commit");
    repeat (3) tick();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d scheduled checks never reached, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
